// File: rtl/regfile_wb_pkg.sv
// rtl/regfile_wb_pkg.sv - shared types and widths for the register file write-back path
//   REG_ADDR_W/REG_DATA_W : register file address/data widths
//   NUM_REGS              : number of architectural registers (busy mask width)
//   wb_req_t              : one queued write {addr, data}
//   wb_src_t              : arbitration winner
//   onehot()              : register address to busy-mask bit
package regfile_wb_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;
  localparam int NUM_REGS   = 1 << REG_ADDR_W;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [REG_DATA_W-1:0] data;
  } wb_req_t;

  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_ALU,
    SRC_MEM
  } wb_src_t;

  function automatic logic [NUM_REGS-1:0] onehot(input logic [REG_ADDR_W-1:0] a);
    logic [NUM_REGS-1:0] m;
    m    = '0;
    m[a] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// rtl/regfile_wb_arbiter_if.sv - producer and register file signals of the write-back arbiter
//   alu_valid/alu_ready/alu_addr/alu_data : ALU result request handshake
//   mem_valid/mem_ready/mem_addr/mem_data : load return request handshake
//   rf_we/rf_waddr/rf_wdata               : register file write port
//   busy_mask                             : pending-write mask for issue hazard checks
//   modport master : producer/register-file side; modport slave : arbiter side
interface regfile_wb_arbiter_if;
  import regfile_wb_pkg::*;

  logic                  alu_valid;
  logic                  alu_ready;
  logic [REG_ADDR_W-1:0] alu_addr;
  logic [REG_DATA_W-1:0] alu_data;
  logic                  mem_valid;
  logic                  mem_ready;
  logic [REG_ADDR_W-1:0] mem_addr;
  logic [REG_DATA_W-1:0] mem_data;
  logic                  rf_we;
  logic [REG_ADDR_W-1:0] rf_waddr;
  logic [REG_DATA_W-1:0] rf_wdata;
  logic [NUM_REGS-1:0]   busy_mask;

  modport master (
    output alu_valid, alu_addr, alu_data, mem_valid, mem_addr, mem_data,
    input  alu_ready, mem_ready, rf_we, rf_waddr, rf_wdata, busy_mask
  );

  modport slave (
    input  alu_valid, alu_addr, alu_data, mem_valid, mem_addr, mem_data,
    output alu_ready, mem_ready, rf_we, rf_waddr, rf_wdata, busy_mask
  );

endinterface

// File: rtl/wb_fifo.sv
// rtl/wb_fifo.sv - per-source write request FIFO with entry-valid view for the busy mask
//   clk, rst_n       : clock, asynchronous active-low reset
//   push_i, push_req_i: enqueue one request (ignored while full)
//   pop_i            : dequeue the head (ignored while empty)
//   full_o, empty_o  : occupancy flags
//   head_o           : oldest entry
//   vld_o, addrs_o   : per-slot valid flag and destination address
module wb_fifo
  import regfile_wb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 push_i,
  input  wb_req_t                              push_req_i,
  input  logic                                 pop_i,
  output logic                                 full_o,
  output logic                                 empty_o,
  output wb_req_t                              head_o,
  output logic [DEPTH-1:0]                     vld_o,
  output logic [DEPTH-1:0][REG_ADDR_W-1:0]     addrs_o
);

  localparam int AW = $clog2(DEPTH);

  // Pointers carry one extra wrap bit to tell full from empty.
  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count;
  logic [AW-1:0] offs [DEPTH];
  logic          do_push, do_pop;
  wb_req_t       mem_q [DEPTH];

  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign count   = wr_ptr_q - rd_ptr_q;
  assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  // A slot is live when its distance from the read pointer is below the occupancy.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      offs[i]    = AW'(i) - rd_ptr_q[AW-1:0];
      vld_o[i]   = {1'b0, offs[i]} < count;
      addrs_o[i] = mem_q[i].addr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: only slots flagged by the pointers are ever read.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_req_i;
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - two-source write-back arbiter for the register file write port
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of regfile_wb_arbiter_if (producer handshakes,
//                register file write port, busy mask)
//   DEPTH      : entries per source FIFO (power of two, >= 2)
//   STARVE_LIMIT : consecutive ALU losses before ALU is forced to win
module regfile_wb_arbiter
  import regfile_wb_pkg::*;
#(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  regfile_wb_arbiter_if.slave   bus
);

  localparam int              SW    = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0]   LIMIT = SW'(STARVE_LIMIT);

  logic                              alu_full, alu_empty, mem_full, mem_empty;
  logic                              alu_push, mem_push;
  wb_req_t                           alu_req, mem_req, alu_head, mem_head;
  logic [DEPTH-1:0]                  alu_vld, mem_vld;
  logic [DEPTH-1:0][REG_ADDR_W-1:0]  alu_addrs, mem_addrs;
  wb_src_t                           win;
  logic [SW-1:0]                     starve_q, starve_d;
  logic                              rf_we_q, rf_we_d;
  logic [REG_ADDR_W-1:0]             rf_waddr_q, rf_waddr_d;
  logic [REG_DATA_W-1:0]             rf_wdata_q, rf_wdata_d;
  logic [NUM_REGS-1:0]               mask;

  // Ready reflects occupancy only; a same-cycle pop never opens a slot.
  assign bus.alu_ready = !alu_full;
  assign bus.mem_ready = !mem_full;

  // Writes to x0 complete the handshake but are dropped here.
  assign alu_push = bus.alu_valid && !alu_full && (bus.alu_addr != '0);
  assign mem_push = bus.mem_valid && !mem_full && (bus.mem_addr != '0);
  assign alu_req  = '{addr: bus.alu_addr, data: bus.alu_data};
  assign mem_req  = '{addr: bus.mem_addr, data: bus.mem_data};

  wb_fifo #(.DEPTH(DEPTH)) u_alu_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_i     (alu_push),
    .push_req_i (alu_req),
    .pop_i      (win == SRC_ALU),
    .full_o     (alu_full),
    .empty_o    (alu_empty),
    .head_o     (alu_head),
    .vld_o      (alu_vld),
    .addrs_o    (alu_addrs)
  );

  wb_fifo #(.DEPTH(DEPTH)) u_mem_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_i     (mem_push),
    .push_req_i (mem_req),
    .pop_i      (win == SRC_MEM),
    .full_o     (mem_full),
    .empty_o    (mem_empty),
    .head_o     (mem_head),
    .vld_o      (mem_vld),
    .addrs_o    (mem_addrs)
  );

  // Loads normally win; ALU is forced through after STARVE_LIMIT straight losses.
  always_comb begin
    win = SRC_NONE;
    if (!alu_empty && !mem_empty) win = (starve_q == LIMIT) ? SRC_ALU : SRC_MEM;
    else if (!alu_empty)          win = SRC_ALU;
    else if (!mem_empty)          win = SRC_MEM;

    starve_d = starve_q;
    if (alu_empty || win == SRC_ALU) starve_d = '0;
    else if (starve_q != LIMIT)      starve_d = starve_q + 1'b1;
  end

  // Output stage holds addr/data when idle so the port never glitches.
  always_comb begin
    rf_we_d    = (win != SRC_NONE);
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    if (win == SRC_ALU) begin
      rf_waddr_d = alu_head.addr;
      rf_wdata_d = alu_head.data;
    end else if (win == SRC_MEM) begin
      rf_waddr_d = mem_head.addr;
      rf_wdata_d = mem_head.data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_q   <= '0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      starve_q   <= starve_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

  always_comb begin
    mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (alu_vld[i]) mask = mask | onehot(alu_addrs[i]);
      if (mem_vld[i]) mask = mask | onehot(mem_addrs[i]);
    end
    if (rf_we_q) mask = mask | onehot(rf_waddr_q);
    mask[0] = 1'b0;
  end

  assign bus.rf_we     = rf_we_q;
  assign bus.rf_waddr  = rf_waddr_q;
  assign bus.rf_wdata  = rf_wdata_q;
  assign bus.busy_mask = mask;

endmodule
